// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and a long-latency unit.
// Define WB_ARB_STARVE_EN to enable the starvation guard that requests pipeline bubbles.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_we,
  input  logic [4:0]                pipe_rd,
  input  logic [REG_DATA_WIDTH-1:0] pipe_data,
  input  logic                      ll_valid,
  output logic                      ll_ready,
  input  logic [4:0]                ll_rd,
  input  logic [REG_DATA_WIDTH-1:0] ll_data,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [REG_DATA_WIDTH-1:0] rf_wdata,
  output logic [$clog2(DEPTH):0]    pend_cnt,
  output logic                      stall_o
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]                rd_q   [DEPTH];
  logic [REG_DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]          live_q, live_d;
  logic [AW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]               cnt_q, cnt_d;
  logic pipe_eff, empty, accept, pop, bypass, push;
  assign pipe_eff = pipe_we && (pipe_rd != 5'd0);
  assign empty    = (cnt_q == '0);
  assign ll_ready = rst && (cnt_q < (AW+1)'(DEPTH));
  assign accept   = ll_valid && ll_ready;
  assign pop      = rst && !pipe_eff && !empty;
  assign bypass   = !pipe_eff && empty && accept;
  assign push     = accept && !bypass;
  assign pend_cnt = cnt_q;
  always_comb begin
    rf_waddr = pipe_rd;
    rf_wdata = pipe_data;
    rf_we    = pipe_eff;
    if (!pipe_eff && !empty) begin
      rf_waddr = rd_q[rptr_q];
      rf_wdata = data_q[rptr_q];
      rf_we    = live_q[rptr_q] && (rd_q[rptr_q] != 5'd0);
    end else if (bypass) begin
      rf_waddr = ll_rd;
      rf_wdata = ll_data;
      rf_we    = (ll_rd != 5'd0);
    end
    rf_we = rf_we && rst;
  end
  // A concurrent writeback is always younger, so it kills matching entries and the incoming result
  always_comb begin
    live_d = live_q;
    if (pipe_eff)
      for (int i = 0; i < DEPTH; i++)
        if (rd_q[i] == pipe_rd) live_d[i] = 1'b0;
    if (push) live_d[wptr_q] = !(pipe_eff && (ll_rd == pipe_rd));
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      live_q <= live_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]   <= ll_rd;
      data_q[wptr_q] <= ll_data;
    end
  end
`ifdef WB_ARB_STARVE_EN
  logic [7:0] starve_q, starve_d;
  logic       stall_q, stall_d;
  always_comb begin
    stall_d  = 1'b0;
    starve_d = 8'd0;
    if (!empty && !pop) begin
      if (starve_q == 8'(STARVE_LIMIT - 1)) stall_d = 1'b1;
      else starve_d = starve_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q <= 8'd0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end
  assign stall_o = stall_q;
`else
  assign stall_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed stimulus with a write scoreboard for wb_port_arbiter (DEPTH=2).
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0, ll_valid = 1'b0, ll_ready, rf_we, stall_o;
  logic [4:0]  pipe_rd = '0, ll_rd = '0, rf_waddr;
  logic [31:0] pipe_data = '0, ll_data = '0, rf_wdata;
  logic [1:0]  pend_cnt;
`ifdef WB_ARB_STARVE_EN
  localparam bit SE = 1'b1;
`else
  localparam bit SE = 1'b0;
`endif
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  int errs = 0, checks = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8), .REG_DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (rst && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_write: got x%0d=%0h want none", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rf_write", {27'd0, rf_waddr, rf_wdata}, {27'd0, e.a, e.d});
      end
    end
  end

  task automatic set(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    pipe_we = pw; pipe_rd = prd; pipe_data = pd;
    ll_valid = lv; ll_rd = lrd; ll_data = ld;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with active requests: outputs must stay quiet
    set(1, 3, 32'h33, 1, 5, 32'h99);
    tick(); tick();
    @(negedge clk);
    chk("rst_ll_ready", ll_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_stall", stall_o, 0);
    tick();
    rst = 1'b1;
    set(0, 0, 0, 0, 0, 0);
    tick();

    // bypass
    set(0, 0, 0, 1, 5, 32'h1234); expect_wr(5, 32'h1234);
    @(negedge clk); chk("byp_ready", ll_ready, 1); chk("byp_pend", pend_cnt, 0);
    tick();
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("byp_pend_after", pend_cnt, 0);
    tick();

    // priority and drain
    set(1, 3, 32'hA, 1, 7, 32'hB); expect_wr(3, 32'hA);
    @(negedge clk); tick();
    set(0, 0, 0, 0, 0, 0); expect_wr(7, 32'hB);
    @(negedge clk); chk("prio_pend1", pend_cnt, 1);
    tick();
    @(negedge clk); chk("prio_pend0", pend_cnt, 0);
    tick();

    // full buffer: third result held until space frees
    set(1, 1, 32'h100, 1, 11, 32'hC1); expect_wr(1, 32'h100);
    @(negedge clk); chk("full_ready_a", ll_ready, 1); tick();
    set(1, 1, 32'h101, 1, 12, 32'hC2); expect_wr(1, 32'h101);
    @(negedge clk); chk("full_ready_b", ll_ready, 1); chk("full_pend_b", pend_cnt, 1); tick();
    set(1, 1, 32'h102, 1, 13, 32'hC3); expect_wr(1, 32'h102);
    @(negedge clk); chk("full_ready_c", ll_ready, 0); chk("full_pend_c", pend_cnt, 2); tick();
    set(1, 1, 32'h103, 1, 13, 32'hC3); expect_wr(1, 32'h103);
    @(negedge clk); chk("full_ready_d", ll_ready, 0); tick();
    set(0, 0, 0, 1, 13, 32'hC3); expect_wr(11, 32'hC1);
    @(negedge clk); chk("full_ready_e", ll_ready, 0); chk("full_pend_e", pend_cnt, 2); tick();
    expect_wr(12, 32'hC2);
    @(negedge clk); chk("full_ready_f", ll_ready, 1); chk("full_pend_f", pend_cnt, 1); tick();
    set(0, 0, 0, 0, 0, 0); expect_wr(13, 32'hC3);
    @(negedge clk); chk("full_pend_g", pend_cnt, 1); tick();
    @(negedge clk); chk("full_pend_h", pend_cnt, 0); tick();

    // kill of a buffered entry by a younger writeback
    set(1, 2, 32'h20, 1, 9, 32'h55); expect_wr(2, 32'h20);
    @(negedge clk); tick();
    set(1, 9, 32'h66, 0, 0, 0); expect_wr(9, 32'h66);
    @(negedge clk); chk("kill_pend", pend_cnt, 1); tick();
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("kill_pop_we", rf_we, 0); chk("kill_pop_pend", pend_cnt, 1); tick();
    @(negedge clk); chk("kill_drained", pend_cnt, 0); tick();

    // result enqueued dead by a same-cycle writeback to the same rd
    set(1, 4, 32'h44, 1, 4, 32'h77); expect_wr(4, 32'h44);
    @(negedge clk); tick();
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("dead_pop_we", rf_we, 0); chk("dead_pend", pend_cnt, 1); tick();

    // x0 bypass writes nothing
    set(0, 0, 0, 1, 0, 32'hDEAD);
    @(negedge clk); chk("x0_byp_we", rf_we, 0); tick();
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("x0_byp_pend", pend_cnt, 0); tick();

    // pipe_rd=0 write is idle and lets the head pop
    set(1, 6, 32'h60, 1, 8, 32'h88); expect_wr(6, 32'h60);
    @(negedge clk); tick();
    set(1, 0, 32'hFFFF, 0, 0, 0); expect_wr(8, 32'h88);
    @(negedge clk); chk("x0_pipe_pend", pend_cnt, 1); tick();
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("x0_pipe_drained", pend_cnt, 0); tick();

    // buffered rd=0 entry pops without a write
    set(1, 6, 32'h61, 1, 0, 32'h1); expect_wr(6, 32'h61);
    @(negedge clk); tick();
    set(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("x0_buf_we", rf_we, 0); tick();

    // reset mid-operation discards buffered results
    set(1, 2, 32'h22, 1, 15, 32'hF); expect_wr(2, 32'h22);
    @(negedge clk); tick();
    set(0, 0, 0, 0, 0, 0); rst = 1'b0;
    @(negedge clk); chk("mid_rst_we", rf_we, 0); chk("mid_rst_ready", ll_ready, 0); tick();
    rst = 1'b1;
    @(negedge clk); chk("mid_rst_pend", pend_cnt, 0); tick();

    // starvation guard
    set(1, 10, 32'd100, 1, 14, 32'hE); expect_wr(10, 32'd100);
    @(negedge clk); chk("stv_pend0", pend_cnt, 0); tick();
    for (int k = 1; k <= 9; k++) begin
      set(1, 10, 32'd100 + 32'(k), 0, 0, 0); expect_wr(10, 32'd100 + 32'(k));
      @(negedge clk);
      chk($sformatf("stv_stall_%0d", k), stall_o, SE && (k == 9));
      chk($sformatf("stv_pend_%0d", k), pend_cnt, 1);
      tick();
    end
    set(0, 0, 0, 0, 0, 0); expect_wr(14, 32'hE);
    @(negedge clk); chk("stv_stall_10", stall_o, 0); tick();
    @(negedge clk); chk("stv_stall_11", stall_o, 0); chk("stv_pend_11", pend_cnt, 0); tick();

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
